sonar_axil_regs: RTL and testbench
==================================

Name: sonar_axil_regs

Overview:
- AXI4-Lite responder (slave) that an AXI master (processor or VIP master agent) accesses through four 32-bit registers.
- Hosts the MaxSonar PWM measurement core:
  - synchronises the sensor PW pin;
  - measures each high pulse in inch units;
  - compares the result against a software threshold to raise a proximity alert for the haptic driver.
- Sits between the interconnect and the Pmod MAXSONAR connector.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width (only 32 supported)
- C_S_AXI_ADDR_WIDTH, 4, byte address width (4 words)
- CLK_PER_INCH, 14700, clock cycles per inch of pulse (147 us at 100 MHz)
- MAX_INCHES, 255, distance saturation value
- TIMEOUT_CYCLES, 5000000, PW-high cycles before timeout (50 ms)

Ports:
- s00_axi_aclk  in  1  single clock
- s00_axi_aresetn  in  1  synchronous active-low reset
- s00_axi_awaddr  in  4  write address
- s00_axi_awprot  in  3  ignored
- s00_axi_awvalid  in  1  write address valid
- s00_axi_awready  out  1  write address ready
- s00_axi_wdata  in  32  write data
- s00_axi_wstrb  in  4  byte enables
- s00_axi_wvalid  in  1  write data valid
- s00_axi_wready  out  1  write data ready
- s00_axi_bresp  out  2  write response, always 2'b00
- s00_axi_bvalid  out  1  write response valid
- s00_axi_bready  in  1  write response ready
- s00_axi_araddr  in  4  read address
- s00_axi_arprot  in  3  ignored
- s00_axi_arvalid  in  1  read address valid
- s00_axi_arready  out  1  read address ready
- s00_axi_rdata  out  32  read data
- s00_axi_rresp  out  2  read response, always 2'b00
- s00_axi_rvalid  out  1  read data valid
- s00_axi_rready  in  1  read data ready
- sonar_pw  in  1  asynchronous sensor pulse-width pin
- sonar_rx  out  1  ranging enable to sensor (CTRL[0])
- prox_alert  out  1  distance valid and < THRESH

Behaviour:
- Reset: all outputs 0; CTRL=0, THRESH=0, DIST=0, STATUS=0; measurement FSM in IDLE.
- Registers (word index = addr[3:2]):
  - 0 CTRL (RW): bit0 = ranging enable, bit1 = alert enable; other bits read 0.
  - 1 THRESH (RW): bits[7:0] threshold in inches.
  - 2 DIST (RO): bits[7:0] last distance; writes ignored but still acknowledged.
  - 3 STATUS: bit0 = new-sample (W1C), bit1 = timeout (W1C), bit2 = PW synchronised level (RO).
- WSTRB: applies per byte on CTRL/THRESH writes; W1C bits are clear only if byte 0 strobe is set.
- Write channel:
  - Accept when awvalid && wvalid && !bvalid.
  - awready and wready pulse high together for exactly 1 cycle; register updates on that edge.
  - bvalid rises the next cycle and holds until bready.
  - AW without W (or W without AW) waits, no partial acceptance.
- Read channel:
  - Accept when arvalid && !rvalid; arready pulses 1 cycle.
  - rdata is registered; rvalid rises the next cycle and holds with rdata stable until rready.
- Read and write may complete in the same cycle, independently.
- PW path: 2-flop synchroniser, then a 1-cycle delayed copy for edge detect.
- Measurement FSM (runs only while CTRL[0]=1; clearing CTRL[0] forces IDLE next cycle, counters cleared, DIST kept):
  - IDLE: wait for PW low (discard a pulse already in progress at enable) -> ARMED.
  - ARMED: rising edge -> MEASURE; sub-counter=0, inch counter=0.
  - MEASURE:
    - Sub-counter counts to CLK_PER_INCH-1, then wraps and increments the inch counter, which saturates at MAX_INCHES.
    - Falling edge -> DIST<=inch counter, STATUS[0]<=1, go to ARMED.
    - Total high cycles reaching TIMEOUT_CYCLES -> STATUS[1]<=1, DIST unchanged, go to IDLE.
- Priority: a hardware set of a STATUS bit in the same cycle as a W1C of that bit wins (bit stays 1).
- prox_alert is registered: CTRL[1] && (DIST < THRESH[7:0]) && (DIST != 0). It updates 1 cycle after DIST or THRESH changes.
- sonar_rx = CTRL[0], registered.

Test Plan:
- Reset then read all 4 words -> rdata 0x00000000 each, rresp 0; sonar_rx=0, prox_alert=0.
- Write CTRL=0x3, THRESH=0x28 with wstrb 0xF; hold bready low 5 cycles -> bvalid held 5 cycles; readback CTRL=0x3, THRESH=0x28. Write THRESH=0xFFFF_FF10 wstrb 0x1 -> THRESH reads 0x10.
- CTRL=1, CLK_PER_INCH=10, PW high 305 cycles -> DIST=30, STATUS=0x1. W1C STATUS=0x1 -> reads 0x0.
- THRESH=40, CTRL=3, 200-cycle pulse (20 in) -> prox_alert=1. Next pulse 500 cycles (50 in) -> prox_alert=0.
- TIMEOUT_CYCLES=1000, PW held high 1200 cycles -> STATUS[1]=1, DIST keeps previous value, FSM re-arms only after PW goes low.
- Reset mid-MEASURE and mid-bvalid -> all outputs 0 next cycle; a pulse ending after reset produces no DIST update.

Source files
------------

// File: rtl/sonar_axil_regs.sv
// sonar_axil_regs: AXI4-Lite register slave wrapping a MaxSonar PWM range
// measurement core.
//
// The sensor PW pin is synchronised and each high pulse is timed in inch
// units. The result is compared against a software threshold to drive a
// proximity alert for the haptic driver.
//
// Registers (word index = addr[3:2]):
//   0 CTRL   RW  [0] ranging enable, [1] alert enable
//   1 THRESH RW  [7:0] threshold in inches
//   2 DIST   RO  [7:0] last measured distance
//   3 STATUS     [0] new sample (W1C), [1] timeout (W1C), [2] PW level (RO)
//
// Ports:
//   s00_axi_*   AXI4-Lite slave, single clock s00_axi_aclk, sync active-low reset
//   sonar_pw    asynchronous sensor pulse-width input
//   sonar_rx    ranging enable to the sensor (CTRL[0], registered)
//   prox_alert  registered: alert enabled, distance valid and below threshold
//
// Measurement FSM:
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_IDLE    | disabled or just timed out; wait for PW low before arming
//   ST_ARMED   | PW low seen; wait for a rising edge
//   ST_MEASURE | PW high; count sub-inch and inch ticks until fall or timeout
module sonar_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int CLK_PER_INCH       = 14700,
  parameter int MAX_INCHES         = 255,
  parameter int TIMEOUT_CYCLES     = 5000000
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  input  logic                              sonar_pw,
  output logic                              sonar_rx,
  output logic                              prox_alert
);

  localparam int SUB_W = (CLK_PER_INCH > 1) ? $clog2(CLK_PER_INCH) : 1;
  localparam int HI_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_MEASURE} state_t;

  logic                          aw_wready_q, bvalid_q, arready_q, rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                    ctrl_q, status_q;
  logic [7:0]                    thresh_q, dist_q, inch_cnt_q, inch_cnt_d;
  logic [SUB_W-1:0]              sub_cnt_q, sub_cnt_d;
  logic [HI_W-1:0]               hi_cnt_q;
  logic                          pw_meta_q, pw_sync_q, pw_dly_q;
  logic                          sample_set_q, timeout_set_q;
  logic                          sonar_rx_q, prox_alert_q;
  state_t                        state_q;

  logic wr_fire, rd_fire, w1c, pw_rise, pw_fall, sub_wrap;
  logic [1:0] waddr, raddr;

  assign waddr   = s00_axi_awaddr[3:2];
  assign raddr   = s00_axi_araddr[3:2];
  assign wr_fire = aw_wready_q && s00_axi_awvalid && s00_axi_wvalid;
  assign rd_fire = arready_q && s00_axi_arvalid;
  assign w1c     = wr_fire && (waddr == 2'd3) && s00_axi_wstrb[0];
  assign pw_rise = pw_sync_q && !pw_dly_q;
  assign pw_fall = !pw_sync_q && pw_dly_q;

  logic unused_inputs;
  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                           s00_axi_araddr[1:0], s00_axi_wdata[C_S_AXI_DATA_WIDTH-1:8],
                           s00_axi_wstrb[C_S_AXI_DATA_WIDTH/8-1:1]};

  // AXI handshakes and register file
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      aw_wready_q  <= 1'b0;
      bvalid_q     <= 1'b0;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      ctrl_q       <= '0;
      thresh_q     <= '0;
      status_q     <= '0;
      sonar_rx_q   <= 1'b0;
      prox_alert_q <= 1'b0;
    end else begin
      // Ready is a one-cycle pulse; bvalid blocks a second accept until B completes.
      aw_wready_q <= !aw_wready_q && s00_axi_awvalid && s00_axi_wvalid && !bvalid_q;
      if (wr_fire)             bvalid_q <= 1'b1;
      else if (s00_axi_bready) bvalid_q <= 1'b0;

      arready_q <= !arready_q && s00_axi_arvalid && !rvalid_q;
      if (rd_fire) begin
        rdata_q  <= rdata_d;
        rvalid_q <= 1'b1;
      end else if (s00_axi_rready) begin
        rvalid_q <= 1'b0;
      end

      if (wr_fire && s00_axi_wstrb[0]) begin
        if (waddr == 2'd0) ctrl_q   <= s00_axi_wdata[1:0];
        if (waddr == 2'd1) thresh_q <= s00_axi_wdata[7:0];
      end

      // Hardware set wins over a simultaneous W1C.
      status_q[0] <= sample_set_q  || (status_q[0] && !(w1c && s00_axi_wdata[0]));
      status_q[1] <= timeout_set_q || (status_q[1] && !(w1c && s00_axi_wdata[1]));

      sonar_rx_q   <= ctrl_q[0];
      prox_alert_q <= ctrl_q[1] && (dist_q < thresh_q) && (dist_q != 8'd0);
    end
  end

  always_comb begin
    rdata_d = '0;
    case (raddr)
      2'd0: rdata_d[1:0] = ctrl_q;
      2'd1: rdata_d[7:0] = thresh_q;
      2'd2: rdata_d[7:0] = dist_q;
      2'd3: rdata_d[2:0] = {pw_sync_q, status_q};
      default: rdata_d = '0;
    endcase
  end

  // PW synchroniser plus delayed copy for edge detection
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      pw_meta_q <= 1'b0;
      pw_sync_q <= 1'b0;
      pw_dly_q  <= 1'b0;
    end else begin
      pw_meta_q <= sonar_pw;
      pw_sync_q <= pw_meta_q;
      pw_dly_q  <= pw_sync_q;
    end
  end

  // The falling-edge cycle is counted too, so an N-cycle pulse yields N ticks.
  always_comb begin
    sub_wrap   = (sub_cnt_q == SUB_W'(CLK_PER_INCH - 1));
    sub_cnt_d  = sub_wrap ? '0 : sub_cnt_q + 1'b1;
    inch_cnt_d = (sub_wrap && (inch_cnt_q != 8'(MAX_INCHES))) ? inch_cnt_q + 8'd1 : inch_cnt_q;
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      state_q       <= ST_IDLE;
      sub_cnt_q     <= '0;
      inch_cnt_q    <= '0;
      hi_cnt_q      <= '0;
      dist_q        <= '0;
      sample_set_q  <= 1'b0;
      timeout_set_q <= 1'b0;
    end else begin
      sample_set_q  <= 1'b0;
      timeout_set_q <= 1'b0;
      if (!ctrl_q[0]) begin
        state_q    <= ST_IDLE;
        sub_cnt_q  <= '0;
        inch_cnt_q <= '0;
        hi_cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (!pw_sync_q) state_q <= ST_ARMED;
          end
          ST_ARMED: begin
            if (pw_rise) begin
              state_q    <= ST_MEASURE;
              sub_cnt_q  <= '0;
              inch_cnt_q <= '0;
              hi_cnt_q   <= HI_W'(1);
            end
          end
          ST_MEASURE: begin
            if (pw_fall) begin
              dist_q       <= inch_cnt_d;
              sample_set_q <= 1'b1;
              state_q      <= ST_ARMED;
            end else if (hi_cnt_q >= HI_W'(TIMEOUT_CYCLES - 1)) begin
              timeout_set_q <= 1'b1;
              state_q       <= ST_IDLE;
            end else begin
              hi_cnt_q   <= hi_cnt_q + 1'b1;
              sub_cnt_q  <= sub_cnt_d;
              inch_cnt_q <= inch_cnt_d;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign s00_axi_awready = aw_wready_q;
  assign s00_axi_wready  = aw_wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = 2'b00;
  assign sonar_rx        = sonar_rx_q;
  assign prox_alert      = prox_alert_q;

endmodule

// File: tb/tb_sonar_axil_regs.sv
module tb_sonar_axil_regs;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        sonar_pw, sonar_rx, prox_alert;

  int errors = 0;
  int checks = 0;
  int hold_seen;
  logic [1:0]  last_bresp;
  logic [31:0] rd;
  logic [1:0]  rr;

  always #5 clk = ~clk;

  sonar_axil_regs #(
    .CLK_PER_INCH  (10),
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_aresetn(aresetn),
    .s00_axi_awaddr (awaddr),
    .s00_axi_awprot (awprot),
    .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready),
    .s00_axi_wdata  (wdata),
    .s00_axi_wstrb  (wstrb),
    .s00_axi_wvalid (wvalid),
    .s00_axi_wready (wready),
    .s00_axi_bresp  (bresp),
    .s00_axi_bvalid (bvalid),
    .s00_axi_bready (bready),
    .s00_axi_araddr (araddr),
    .s00_axi_arprot (arprot),
    .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready),
    .s00_axi_rdata  (rdata),
    .s00_axi_rresp  (rresp),
    .s00_axi_rvalid (rvalid),
    .s00_axi_rready (rready),
    .sonar_pw       (sonar_pw),
    .sonar_rx       (sonar_rx),
    .prox_alert     (prox_alert)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int hold);
    bit done;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (awready && wready) done = 1;
    end
    if (!done) check("aw_w_handshake_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    hold_seen = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bvalid) hold_seen++;
    end
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bvalid) done = 1;
    end
    if (!done) check("bvalid_timeout", 32'd0, 32'd1);
    last_bresp = bresp;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] r);
    bit done;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (arready) done = 1;
    end
    if (!done) check("ar_handshake_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (rvalid) done = 1;
    end
    if (!done) check("rvalid_timeout", 32'd0, 32'd1);
    d = rdata; r = rresp;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, d, r);
    check(tag, d, exp);
  endtask

  task automatic pulse(input int n);
    @(negedge clk);
    sonar_pw = 1'b1;
    repeat (n) @(negedge clk);
    sonar_pw = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    aresetn = 1'b0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    wdata = '0; wstrb = '0; sonar_pw = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_outputs", {26'd0, awready, wready, bvalid, arready, rvalid, sonar_rx},  32'd0);
    check("rst_prox", {31'd0, prox_alert}, 32'd0);
    aresetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), rd, rr);
      check($sformatf("rst_read_w%0d", i), rd, 32'd0);
      check($sformatf("rst_rresp_w%0d", i), {30'd0, rr}, 32'd0);
    end

    // Register writes, B backpressure, byte strobes
    axi_write(4'h0, 32'h0000_0003, 4'hF, 5);
    check("bvalid_hold_cycles", hold_seen, 32'd5);
    check("bresp", {30'd0, last_bresp}, 32'd0);
    axi_write(4'h4, 32'h0000_0028, 4'hF, 0);
    read_check("ctrl_rb", 4'h0, 32'h3);
    read_check("thresh_rb", 4'h4, 32'h28);
    check("sonar_rx_on", {31'd0, sonar_rx}, 32'd1);
    axi_write(4'h4, 32'hFFFF_FF10, 4'h1, 0);
    read_check("thresh_strb1", 4'h4, 32'h10);
    axi_write(4'h0, 32'h0000_0000, 4'hE, 0);
    read_check("ctrl_strb_no_b0", 4'h0, 32'h3);

    // Basic measurement and W1C
    axi_write(4'h0, 32'h1, 4'hF, 0);
    repeat (5) @(negedge clk);
    pulse(305);
    read_check("dist_30", 4'h8, 32'd30);
    read_check("status_new", 4'hC, 32'h1);
    axi_write(4'hC, 32'h1, 4'h0, 0);
    read_check("w1c_no_strb", 4'hC, 32'h1);
    axi_write(4'hC, 32'h1, 4'h1, 0);
    read_check("w1c_clear", 4'hC, 32'h0);
    axi_write(4'h8, 32'h55, 4'hF, 0);
    read_check("dist_ro", 4'h8, 32'd30);

    // Proximity alert
    axi_write(4'h4, 32'd40, 4'hF, 0);
    axi_write(4'h0, 32'h3, 4'hF, 0);
    pulse(200);
    read_check("dist_20", 4'h8, 32'd20);
    check("prox_on", {31'd0, prox_alert}, 32'd1);
    pulse(500);
    read_check("dist_50", 4'h8, 32'd50);
    check("prox_off", {31'd0, prox_alert}, 32'd0);
    axi_write(4'hC, 32'h1, 4'h1, 0);

    // Timeout: PW held high beyond 1000 cycles
    @(negedge clk);
    sonar_pw = 1'b1;
    repeat (1100) @(negedge clk);
    read_check("status_timeout_pw_hi", 4'hC, 32'h6);
    repeat (100) @(negedge clk);
    sonar_pw = 1'b0;
    repeat (10) @(negedge clk);
    read_check("status_after_to", 4'hC, 32'h2);
    read_check("dist_kept_to", 4'h8, 32'd50);
    pulse(100);
    read_check("dist_rearm_10", 4'h8, 32'd10);
    read_check("status_rearm", 4'hC, 32'h3);
    check("prox_rearm", {31'd0, prox_alert}, 32'd1);

    // Reset during MEASURE and with B pending
    @(negedge clk);
    sonar_pw = 1'b1;
    repeat (50) @(negedge clk);
    awaddr = 4'h4; wdata = 32'h7; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    repeat (4) @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("bvalid_pending", {31'd0, bvalid}, 32'd1);
    aresetn = 1'b0;
    @(negedge clk);
    check("rst2_outputs", {26'd0, awready, wready, bvalid, arready, rvalid, sonar_rx}, 32'd0);
    check("rst2_prox_rdata", {31'd0, prox_alert} | rdata, 32'd0);
    @(negedge clk);
    aresetn = 1'b1;
    repeat (20) @(negedge clk);
    sonar_pw = 1'b0;
    repeat (10) @(negedge clk);
    read_check("rst2_dist", 4'h8, 32'd0);
    read_check("rst2_status", 4'hC, 32'h0);
    read_check("rst2_ctrl", 4'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
